// File: rtl/pix_stream_pkg.sv
// Shared types, widths and pixel-pattern helpers for the synthetic raw-Bayer source.
package pix_stream_pkg;

  localparam int COORD_W = 11;
  localparam int DATA_W  = 12;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_BAYER = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_mode_e;

  localparam logic [DATA_W-1:0] BAYER_G   = 12'h800;
  localparam logic [DATA_W-1:0] BAYER_R   = 12'hFFF;
  localparam logic [DATA_W-1:0] BAYER_B   = 12'h100;
  localparam logic [DATA_W-1:0] LFSR_SEED = 12'hACE;

  // x^12+x^6+x^4+x+1, Fibonacci form, shifting left
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] q);
    return {q[10:0], q[11] ^ q[5] ^ q[3] ^ q[0]};
  endfunction

  function automatic logic [DATA_W-1:0] pix_value(
    input pat_mode_e          mode,
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [CNT_W-1:0]   cnt,
    input logic [DATA_W-1:0]  lfsr
  );
    case (mode)
      PAT_HRAMP: return {1'b0, x} + DATA_W'(cnt);
      PAT_VRAMP: return {1'b0, y};
      PAT_BAYER: begin
        if (y[0] == 1'b0) return x[0] ? BAYER_R : BAYER_G;
        else              return x[0] ? BAYER_G : BAYER_B;
      end
      default:   return lfsr;
    endcase
  endfunction

endpackage

// File: rtl/raw_pattern_gen_if.sv
// Camera-side pixel bus: data/valid plus raster coordinates and frame markers.
interface raw_pattern_gen_if;
  import pix_stream_pkg::*;

  logic [DATA_W-1:0]  oDATA;
  logic               oDVAL;
  logic [COORD_W-1:0] oX_Cont;
  logic [COORD_W-1:0] oY_Cont;
  logic               oFrame_Start;
  logic               oFrame_End;
  logic [CNT_W-1:0]   oFrame_Cnt;

  modport master (output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Start, oFrame_End, oFrame_Cnt);
  modport slave  (input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Start, oFrame_End, oFrame_Cnt);
endinterface

// File: rtl/lfsr12.sv
// 12-bit pattern LFSR; q always holds the value of the pixel currently on the bus.
module lfsr12
  import pix_stream_pkg::*;
(
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge iCLK) begin
    if (iRST || load) begin
      q <= LFSR_SEED;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/raw_pattern_gen.sv
// Synthetic raster source: ACTIVE lines separated by H/V blanking, one pixel per clock.
// Outputs are registered; the comb block decides what the next cycle shows.
module raw_pattern_gen
  import pix_stream_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  input  logic [1:0]        iMODE,
  raw_pattern_gen_if.master pix
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_ACTIVE - 1);
  localparam logic [11:0]        HB_LAST = 12'(H_BLANK - 1);
  localparam logic [11:0]        VB_LAST = 12'(V_BLANK - 1);

  state_e             state;
  pat_mode_e          mode_q, mode_eff;
  logic [COORD_W-1:0] x_q, y_q, nx, ny;
  logic [11:0]        bcnt;
  logic [DATA_W-1:0]  data_q, lfsr_q, lfsr_eff;
  logic [CNT_W-1:0]   cnt_q, cnt_eff;
  logic               dval_q, fs_q, fe_q;
  logic               emit, new_frame, eol;

  always_comb begin
    new_frame = 1'b0;
    emit      = 1'b0;
    eol       = 1'b0;
    nx        = x_q + 1'b1;
    ny        = y_q;
    case (state)
      IDLE:    new_frame = iEN;
      ACTIVE:  if (x_q != X_LAST) emit = 1'b1;
               else eol = (H_BLANK == 0);
      HBLANK:  eol = (bcnt == HB_LAST);
      VBLANK:  new_frame = (bcnt == VB_LAST) && iEN;
      default: ;
    endcase
    if (eol) begin
      if (y_q != Y_LAST) begin
        emit = 1'b1;
        nx   = '0;
        ny   = y_q + 1'b1;
      end else if (V_BLANK == 0) begin
        new_frame = iEN;
      end
    end
    if (new_frame) begin
      emit = 1'b1;
      nx   = '0;
      ny   = '0;
    end
  end

  // The frame count steps the cycle after the end pulse, so a back-to-back frame sees it already bumped.
  assign cnt_eff  = cnt_q + CNT_W'(fe_q);
  assign mode_eff = new_frame ? pat_mode_e'(iMODE) : mode_q;
  assign lfsr_eff = new_frame ? LFSR_SEED : lfsr_next(lfsr_q);

  lfsr12 u_lfsr (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .load    (new_frame),
    .advance (emit && !new_frame),
    .q       (lfsr_q)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= IDLE;
      mode_q <= PAT_HRAMP;
      x_q    <= '0;
      y_q    <= '0;
      bcnt   <= '0;
      data_q <= '0;
      dval_q <= 1'b0;
      fs_q   <= 1'b0;
      fe_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dval_q <= emit;
      fs_q   <= new_frame;
      fe_q   <= emit && (nx == X_LAST) && (ny == Y_LAST);
      data_q <= emit ? pix_value(mode_eff, nx, ny, cnt_eff, lfsr_eff) : '0;
      cnt_q  <= cnt_eff;
      if (emit) begin
        x_q <= nx;
        y_q <= ny;
      end
      if (new_frame) mode_q <= mode_eff;
      if (emit) begin
        state <= ACTIVE;
      end else begin
        case (state)
          ACTIVE: begin
            bcnt  <= '0;
            state <= (H_BLANK != 0) ? HBLANK : ((V_BLANK != 0) ? VBLANK : IDLE);
          end
          HBLANK: begin
            if (bcnt == HB_LAST) begin
              bcnt  <= '0;
              state <= (V_BLANK != 0) ? VBLANK : IDLE;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          VBLANK: begin
            if (bcnt == VB_LAST) state <= IDLE;
            else                 bcnt  <= bcnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign pix.oDATA        = data_q;
  assign pix.oDVAL        = dval_q;
  assign pix.oX_Cont      = x_q;
  assign pix.oY_Cont      = y_q;
  assign pix.oFrame_Start = fs_q;
  assign pix.oFrame_End   = fe_q;
  assign pix.oFrame_Cnt   = cnt_q;

endmodule

// File: tb/tb_raw_pattern_gen.sv
// Scoreboarded bench: 4x3 frames with blanking (dut_a) and without blanking (dut_b).
module tb_raw_pattern_gen;

  typedef struct packed {
    logic [31:0] t;
    logic [11:0] data;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        fe;
    logic [7:0]  cnt;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, en_a = 1'b0, rst_b = 1'b1, en_b = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
  int         cyc = 0;
  int         nvec = 0;
  int         nerr = 0;
  pix_t       qa[$];
  pix_t       qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  raw_pattern_gen_if pa ();
  raw_pattern_gen_if pb ();

  raw_pattern_gen #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .V_BLANK(3)) dut_a (
    .iCLK(clk), .iRST(rst_a), .iEN(en_a), .iMODE(mode_a), .pix(pa)
  );
  raw_pattern_gen #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(0), .V_BLANK(0)) dut_b (
    .iCLK(clk), .iRST(rst_b), .iEN(en_b), .iMODE(mode_b), .pix(pb)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_data(input int mode, input int x, input int y,
                                           input int cnt, input logic [11:0] lf);
    case (mode)
      0: return 12'(x + cnt);
      1: return 12'(y);
      2: begin
        if (y % 2 == 0) return (x % 2 == 0) ? 12'h800 : 12'hFFF;
        else            return (x % 2 == 0) ? 12'h100 : 12'h800;
      end
      default: return lf;
    endcase
  endfunction

  // Queue the first npix raster pixels of a 4x3 frame whose (0,0) appears at cycle start.
  task automatic push_frame(input bit to_b, input int start, input int mode, input int cnt,
                            input int npix, input int hb);
    logic [11:0] lf;
    pix_t        e;
    lf = 12'hACE;
    for (int i = 0; i < npix; i++) begin
      int x;
      int y;
      x      = i % 4;
      y      = i / 4;
      e.t    = 32'(start + y * (4 + hb) + x);
      e.data = exp_data(mode, x, y, cnt, lf);
      e.x    = 11'(x);
      e.y    = 11'(y);
      e.fs   = (i == 0);
      e.fe   = (i == 11);
      e.cnt  = 8'(cnt);
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
      lf = {lf[10:0], lf[11] ^ lf[5] ^ lf[3] ^ lf[0]};
    end
  endtask

  task automatic check_pix(input string name, input pix_t got, input pix_t exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got t=%0d data=%h x=%0d y=%0d fs=%b fe=%b cnt=%0d, expected t=%0d data=%h x=%0d y=%0d fs=%b fe=%b cnt=%0d",
               name, got.t, got.data, got.x, got.y, got.fs, got.fe, got.cnt,
               exp.t, exp.data, exp.x, exp.y, exp.fs, exp.fe, exp.cnt);
    end
  endtask

  always @(negedge clk) begin
    pix_t g;
    g = {32'(cyc), pa.oDATA, pa.oX_Cont, pa.oY_Cont, pa.oFrame_Start, pa.oFrame_End, pa.oFrame_Cnt};
    if (pa.oDVAL === 1'b1) begin
      if (qa.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL pix_a_unexpected: got pixel at t=%0d x=%0d y=%0d, expected none", cyc, g.x, g.y);
      end else begin
        check_pix("pix_a", g, qa.pop_front());
      end
    end else begin
      chk("quiet_a", {pa.oDVAL, pa.oDATA, pa.oFrame_Start, pa.oFrame_End}, 64'd0);
    end
  end

  always @(negedge clk) begin
    pix_t g;
    g = {32'(cyc), pb.oDATA, pb.oX_Cont, pb.oY_Cont, pb.oFrame_Start, pb.oFrame_End, pb.oFrame_Cnt};
    if (pb.oDVAL === 1'b1) begin
      if (qb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL pix_b_unexpected: got pixel at t=%0d x=%0d y=%0d, expected none", cyc, g.x, g.y);
      end else begin
        check_pix("pix_b", g, qb.pop_front());
      end
    end else begin
      chk("quiet_b", {pb.oDVAL, pb.oDATA, pb.oFrame_Start, pb.oFrame_End}, 64'd0);
    end
  end

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    en_a  = 1'b0;
    @(negedge clk);
    chk("reset_state_a", {pa.oDVAL, pa.oDATA, pa.oX_Cont, pa.oY_Cont,
                          pa.oFrame_Start, pa.oFrame_End, pa.oFrame_Cnt}, 64'd0);
    rst_a = 1'b0;
  endtask

  initial begin
    int s;
    @(negedge clk);

    // H-ramp, two back-to-back frames; second frame ramps from 1
    reset_a();
    en_a = 1'b1; mode_a = 2'd0; s = cyc + 1;
    push_frame(0, s, 0, 0, 12, 2);
    push_frame(0, s + 21, 0, 1, 12, 2);
    at(s + 21 + 17);
    chk("frame_cnt_after_two", 64'(pa.oFrame_Cnt), 64'd2);

    // Bayer mosaic
    reset_a();
    en_a = 1'b1; mode_a = 2'd2; s = cyc + 1;
    push_frame(0, s, 2, 0, 12, 2);
    at(s + 17);

    // LFSR, reseeded at the second frame
    reset_a();
    en_a = 1'b1; mode_a = 2'd3; s = cyc + 1;
    push_frame(0, s, 3, 0, 12, 2);
    push_frame(0, s + 21, 3, 1, 12, 2);
    at(s + 21 + 17);

    // iEN and iMODE change at pixel (1,1): frame completes unchanged, then idle
    reset_a();
    en_a = 1'b1; mode_a = 2'd0; s = cyc + 1;
    push_frame(0, s, 0, 0, 12, 2);
    at(s + 7);
    en_a = 1'b0; mode_a = 2'd1;
    at(s + 50);
    chk("idle_after_drop_dval", 64'(pa.oDVAL), 64'd0);
    chk("idle_after_drop_cnt", 64'(pa.oFrame_Cnt), 64'd1);

    // Reset at pixel (2,1) with iEN held, then restart
    reset_a();
    en_a = 1'b1; mode_a = 2'd0; s = cyc + 1;
    push_frame(0, s, 0, 0, 7, 2);
    at(s + 8);
    rst_a = 1'b1;
    @(negedge clk);
    chk("midframe_reset_state", {pa.oDVAL, pa.oDATA, pa.oX_Cont, pa.oY_Cont,
                                 pa.oFrame_Start, pa.oFrame_End, pa.oFrame_Cnt}, 64'd0);
    rst_a = 1'b0;
    push_frame(0, s + 10, 0, 0, 12, 2);
    at(s + 10 + 17);
    en_a = 1'b0;
    at(s + 10 + 40);
    chk("restart_frame_cnt", 64'(pa.oFrame_Cnt), 64'd1);

    // No blanking: continuous valid; mode change mid-frame takes effect next frame
    rst_b = 1'b0; en_b = 1'b1; mode_b = 2'd1; s = cyc + 1;
    push_frame(1, s, 1, 0, 12, 0);
    push_frame(1, s + 12, 2, 1, 12, 0);
    at(s + 5);
    mode_b = 2'd2;
    at(s + 12 + 5);
    en_b = 1'b0;
    at(s + 40);
    chk("nobl_idle_dval", 64'(pb.oDVAL), 64'd0);
    chk("nobl_frame_cnt", 64'(pb.oFrame_Cnt), 64'd2);

    chk("queue_a_drained", 64'(qa.size()), 64'd0);
    chk("queue_b_drained", 64'(qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
